// File: rtl/dut.sv
// dut: self-checking LFSR-fill, bubble-sort and verify kernel that reports an exit code
module dut #(
  parameter int          N            = 16,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          WATCHDOG     = 4096,
  parameter int          FAULT_INJECT = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] hpr_abend_syndrome
);
  localparam int IW = $clog2(N);
  localparam int SW = IW + 16;
  typedef enum logic [1:0] {FILL, SORT, CHECK, EXIT} state_t;
  state_t         state;
  logic [15:0]    mem [N];
  logic [IW-1:0]  i, j, k, jp, km;
  logic [15:0]    lfsr, lfsr_next, chk_val;
  logic [SW-1:0]  sum_fill, sum_chk;
  logic [12:0]    cyc;
  logic           order_err, swap, pass_end, wd;
  always_comb begin
    jp        = j + IW'(1);
    km        = k - IW'(1);
    lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    swap      = state == SORT && mem[j] > mem[jp] && FAULT_INJECT != 1;
    pass_end  = j == IW'(N - 2) - i;
    chk_val   = (FAULT_INJECT == 2 && k == '0) ? mem[k] ^ 16'h0001 : mem[k];
    wd        = hpr_abend_syndrome == 8'hFF && int'(cyc) + 1 >= WATCHDOG;
  end
  always_ff @(posedge clk) begin
    if (!wd && state == FILL) mem[i] <= lfsr;
    if (!wd && swap) begin
      mem[j]  <= mem[jp];
      mem[jp] <= mem[j];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= FILL;
      i                  <= '0;
      j                  <= '0;
      k                  <= '0;
      lfsr               <= SEED;
      sum_fill           <= '0;
      sum_chk            <= '0;
      cyc                <= '0;
      order_err          <= 1'b0;
      hpr_abend_syndrome <= 8'hFF;
    end else begin
      cyc <= (&cyc) ? cyc : cyc + 13'd1;
      if (wd) begin
        state              <= EXIT;
        hpr_abend_syndrome <= 8'h03;
      end else begin
        case (state)
          FILL: begin
            mem_fill_step: begin
              sum_fill <= sum_fill + SW'(lfsr);
              lfsr     <= lfsr_next;
              i        <= (i == IW'(N - 1)) ? '0 : i + IW'(1);
              j        <= '0;
              if (i == IW'(N - 1)) state <= SORT;
            end
          end
          SORT: begin
            j <= pass_end ? '0 : jp;
            if (pass_end) i <= i + IW'(1);
            if (pass_end && i == IW'(N - 2)) begin
              state <= CHECK;
              k     <= '0;
            end
          end
          CHECK: begin
            sum_chk <= sum_chk + SW'(chk_val);
            if (k != '0 && mem[km] > mem[k]) order_err <= 1'b1;
            k <= k + IW'(1);
            if (k == IW'(N - 1)) state <= EXIT;
          end
          default: begin
            if (hpr_abend_syndrome == 8'hFF)
              hpr_abend_syndrome <= order_err ? 8'h01 : (sum_chk != sum_fill) ? 8'h02 : 8'h00;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dut.sv
// tb_dut: scoreboard bench running six parameterised kernels against their expected exit timelines
module tb_dut;
  localparam int LAST = 260;
  typedef struct {
    int          idx;
    int          e;
    logic [7:0]  exp;
  } item_t;
  logic       clk = 1'b0;
  logic       rst_a = 1'b0;
  logic       rst_b = 1'b0;
  logic [7:0] syn [6];
  item_t      sb [$];
  int         checks = 0;
  int         failures = 0;
  always #5 clk = ~clk;
  dut u0 (.clk(clk), .reset(rst_a), .hpr_abend_syndrome(syn[0]));
  dut #(.FAULT_INJECT(1)) u1 (.clk(clk), .reset(rst_a), .hpr_abend_syndrome(syn[1]));
  dut #(.FAULT_INJECT(2)) u2 (.clk(clk), .reset(rst_a), .hpr_abend_syndrome(syn[2]));
  dut #(.WATCHDOG(100)) u3 (.clk(clk), .reset(rst_a), .hpr_abend_syndrome(syn[3]));
  dut #(.N(2), .SEED(16'h0000)) u4 (.clk(clk), .reset(rst_a), .hpr_abend_syndrome(syn[4]));
  dut u5 (.clk(clk), .reset(rst_b), .hpr_abend_syndrome(syn[5]));
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] exp_of(input int idx, input int e);
    case (idx)
      0:       return e >= 153 ? 8'h00 : 8'hFF;
      1:       return e >= 153 ? 8'h01 : 8'hFF;
      2:       return e >= 153 ? 8'h02 : 8'hFF;
      3:       return e >= 100 ? 8'h03 : 8'hFF;
      4:       return e >= 6 ? 8'h00 : 8'hFF;
      default: return (e > 71 && e - 71 >= 153) ? 8'h00 : 8'hFF;
    endcase
  endfunction
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < 6; n++) check($sformatf("reset_u%0d", n), syn[n], 8'hFF);
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int e = 1; e <= LAST; e++) begin
      rst_b = (e != 71);
      if (e == 71) begin
        #1;
        check("async_u5", syn[5], 8'hFF);
      end
      for (int n = 0; n < 6; n++) sb.push_back('{idx: n, e: e, exp: exp_of(n, e)});
      @(negedge clk);
      while (sb.size() > 0) begin
        item_t it;
        it = sb.pop_front();
        check($sformatf("u%0d_edge%0d", it.idx, it.e), syn[it.idx], it.exp);
      end
    end
    #2 rst_a = 1'b0;
    #1;
    check("async_u0", syn[0], 8'hFF);
    check("async_u3", syn[3], 8'hFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
